// File: rtl/cv32e40p_apu_arbiter_if.sv
// Bundles the per-core APU channels and the shared-APU channel that the arbiter sits between.
// Latency: none (wires only).
// Backpressure: req/gnt on both sides; results have no backpressure (rvalid only).
// Ports: core_apu_* are the per-core request/response signals, apu_* the shared unit's.
// Modport slave is the arbiter's view; master is the view of the cores plus shared APU.
interface cv32e40p_apu_arbiter_if #(
  parameter int NUM_CORES        = 4,
  parameter int APU_NARGS_CPU    = 3,
  parameter int APU_WOP_CPU      = 6,
  parameter int APU_NDSFLAGS_CPU = 15,
  parameter int APU_NUSFLAGS_CPU = 5
);
  // core side
  logic [NUM_CORES-1:0]                          core_apu_req_i;
  logic [NUM_CORES-1:0]                          core_apu_gnt_o;
  logic [NUM_CORES-1:0][APU_NARGS_CPU-1:0][31:0] core_apu_operands_i;
  logic [NUM_CORES-1:0][APU_WOP_CPU-1:0]         core_apu_op_i;
  logic [NUM_CORES-1:0][APU_NDSFLAGS_CPU-1:0]    core_apu_flags_i;
  logic [NUM_CORES-1:0]                          core_apu_rvalid_o;
  logic [31:0]                                   core_apu_result_o;
  logic [APU_NUSFLAGS_CPU-1:0]                   core_apu_flags_o;
  // shared APU side
  logic                                          apu_req_o;
  logic                                          apu_gnt_i;
  logic [APU_NARGS_CPU-1:0][31:0]                apu_operands_o;
  logic [APU_WOP_CPU-1:0]                        apu_op_o;
  logic [APU_NDSFLAGS_CPU-1:0]                   apu_flags_o;
  logic                                          apu_rvalid_i;
  logic [31:0]                                   apu_result_i;
  logic [APU_NUSFLAGS_CPU-1:0]                   apu_flags_i;

  modport slave (
    input  core_apu_req_i, core_apu_operands_i, core_apu_op_i, core_apu_flags_i,
           apu_gnt_i, apu_rvalid_i, apu_result_i, apu_flags_i,
    output core_apu_gnt_o, core_apu_rvalid_o, core_apu_result_o, core_apu_flags_o,
           apu_req_o, apu_operands_o, apu_op_o, apu_flags_o
  );

  modport master (
    output core_apu_req_i, core_apu_operands_i, core_apu_op_i, core_apu_flags_i,
           apu_gnt_i, apu_rvalid_i, apu_result_i, apu_flags_i,
    input  core_apu_gnt_o, core_apu_rvalid_o, core_apu_result_o, core_apu_flags_o,
           apu_req_o, apu_operands_o, apu_op_o, apu_flags_o
  );
endinterface

// File: rtl/cv32e40p_apu_arbiter.sv
// Round-robin share of one APU between NUM_CORES cores; in-order tag FIFO routes results back.
// Latency: zero cycles request->APU and result->core (combinational); state updates next cycle.
// Backpressure: apu_req_o drops while the tag FIFO is full; an ungranted winner is locked.
// Ports: clk_i/rst_i (async active-high), bus (slave view of the APU channels),
//        outstanding_o (tag FIFO occupancy), err_o (sticky result-without-operation flag).
module cv32e40p_apu_arbiter #(
  parameter int NUM_CORES        = 4,
  parameter int MAX_OUTSTANDING  = 4,
  parameter int APU_NARGS_CPU    = 3,
  parameter int APU_WOP_CPU      = 6,
  parameter int APU_NDSFLAGS_CPU = 15,
  parameter int APU_NUSFLAGS_CPU = 5
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  cv32e40p_apu_arbiter_if.slave              bus,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_o,
  output logic                               err_o
);
  localparam int IDW = $clog2(NUM_CORES);
  localparam int AW  = $clog2(MAX_OUTSTANDING);
  localparam int PW  = AW + 1;  // extra wrap bit separates full from empty

  logic [IDW-1:0] r_rr;
  logic           r_lock_vld;
  logic [IDW-1:0] r_lock_id;
  logic           r_err;
  logic [PW-1:0]  r_wr_ptr;
  logic [PW-1:0]  r_rd_ptr;
  logic [IDW-1:0] r_tag [MAX_OUTSTANDING];

  logic [IDW-1:0] w_rr_win;
  logic [IDW-1:0] w_win;
  logic [IDW-1:0] w_rr_nxt;
  logic           w_any_req;
  logic           w_full;
  logic           w_empty;
  logic           w_req;
  logic           w_push;
  logic           w_pop;

  // First requester at or after r_rr, wrapping modulo NUM_CORES.
  always_comb begin : rr_search
    logic           found;
    logic [IDW-1:0] cand;
    found    = 1'b0;
    cand     = '0;
    w_rr_win = r_rr;
    for (int i = 0; i < NUM_CORES; i++) begin
      cand = IDW'((int'(r_rr) + i) % NUM_CORES);
      if (!found && bus.core_apu_req_i[cand]) begin
        found    = 1'b1;
        w_rr_win = cand;
      end
    end
  end

  // A shown-but-ungranted request stays the winner until granted; the core
  // holds its req meanwhile, so the forwarded payload cannot change.
  assign w_win     = r_lock_vld ? r_lock_id : w_rr_win;
  assign w_rr_nxt  = (w_win == IDW'(NUM_CORES - 1)) ? '0 : w_win + 1'b1;

  assign w_any_req = |bus.core_apu_req_i;
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  // Deliberately independent of apu_gnt_i / apu_rvalid_i.
  assign w_req     = w_any_req & ~w_full;
  assign w_push    = w_req & bus.apu_gnt_i;
  assign w_pop     = bus.apu_rvalid_i & ~w_empty;

  // request path
  assign bus.apu_req_o      = w_req;
  assign bus.core_apu_gnt_o = w_push ? (NUM_CORES'(1) << w_win) : '0;
  assign bus.apu_operands_o = w_req ? bus.core_apu_operands_i[w_win] : '0;
  assign bus.apu_op_o       = w_req ? bus.core_apu_op_i[w_win]       : '0;
  assign bus.apu_flags_o    = w_req ? bus.core_apu_flags_i[w_win]    : '0;

  // response path: results come back in issue order, so the FIFO head owns them
  assign bus.core_apu_rvalid_o = w_pop ? (NUM_CORES'(1) << r_tag[r_rd_ptr[AW-1:0]]) : '0;
  assign bus.core_apu_result_o = bus.apu_result_i;
  assign bus.core_apu_flags_o  = bus.apu_flags_i;

  assign outstanding_o = r_wr_ptr - r_rd_ptr;
  assign err_o         = r_err;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rr       <= '0;
      r_lock_vld <= 1'b0;
      r_lock_id  <= '0;
      r_err      <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr   <= r_wr_ptr + 1'b1;
        r_rr       <= w_rr_nxt;
        r_lock_vld <= 1'b0;
      end else if (w_req) begin
        // shown but not granted: freeze this winner
        r_lock_vld <= 1'b1;
        r_lock_id  <= w_win;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (bus.apu_rvalid_i && w_empty) begin
        r_err <= 1'b1;
      end
    end
  end

  // Tag storage needs no reset: entries are only read between push and pop.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_tag[r_wr_ptr[AW-1:0]] <= w_win;
    end
  end
endmodule

// File: doc/cv32e40p_apu_arbiter.md
# cv32e40p_apu_arbiter

Shares a single APU/FPU instance between `NUM_CORES` cv32e40p cores in a PULP cluster. It arbitrates the per-core APU request channels round-robin, forwards the winning request's payload to the shared unit, and records the requester ID of every accepted operation in an in-order tag FIFO. Each returning result is routed back to the core that issued it. The block sits between the cores' `apu_*` ports and the shared FPU's request/response interface.

## Interface
- `NUM_CORES`, default 4: number of requesters, 2..16.
- `MAX_OUTSTANDING`, default 4: tag FIFO depth; must be a power of 2, ≥2.
- `APU_NARGS_CPU`, default 3: operand count.
- `APU_WOP_CPU`, default 6: op width.
- `APU_NDSFLAGS_CPU`, default 15: downstream flag width.
- `APU_NUSFLAGS_CPU`, default 5: upstream flag width.
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `core_apu_req_i` in NUM_CORES: per-core request.
- `core_apu_gnt_o` out NUM_CORES: per-core grant.
- `core_apu_operands_i` in NUM_CORES×APU_NARGS_CPU×32: per-core operands.
- `core_apu_op_i` in NUM_CORES×APU_WOP_CPU: per-core op.
- `core_apu_flags_i` in NUM_CORES×APU_NDSFLAGS_CPU: per-core flags.
- `core_apu_rvalid_o` out NUM_CORES: one-hot result valid.
- `core_apu_result_o` out 32: result, broadcast to all cores.
- `core_apu_flags_o` out APU_NUSFLAGS_CPU: result flags, broadcast to all cores.
- `apu_req_o` out 1: request to the shared APU.
- `apu_gnt_i` in 1: grant from the shared APU.
- `apu_operands_o` out APU_NARGS_CPU×32: forwarded operands.
- `apu_op_o` out APU_WOP_CPU: forwarded op.
- `apu_flags_o` out APU_NDSFLAGS_CPU: forwarded flags.
- `apu_rvalid_i` in 1: result valid from the shared APU.
- `apu_result_i` in 32: result from the shared APU.
- `apu_flags_i` in APU_NUSFLAGS_CPU: result flags from the shared APU.
- `outstanding_o` out $clog2(MAX_OUTSTANDING)+1: current tag FIFO occupancy.
- `err_o` out 1: sticky error, set when a result arrives with no operation outstanding.

## Operation
**Arbitration**
- Round-robin pointer `rr_q` (starts at 0).
- The winner is the first core with `core_apu_req_i` set, searching from `rr_q` upward and wrapping modulo NUM_CORES.

**Lock**
- A lock register `lock_q` holds a winner ID while its request is shown but not yet granted.
- If `apu_req_o`=1 and `apu_gnt_i`=0: `lock_q` is set and the winner is frozen. No re-arbitration happens while locked.
- Cores hold `req` until granted, per the OBI rule, so the forwarded payload stays stable while locked.

**Request path**
- `apu_req_o` = (any `core_apu_req_i`) AND (FIFO not full).
- `apu_operands_o`, `apu_op_o`, `apu_flags_o` = the winner's payload. When `apu_req_o`=0 they are all zeros.

**Handshake**
- Handshake occurs when `apu_req_o` AND `apu_gnt_i`.
- `core_apu_gnt_o[w]`=1 only for the winner `w`, combinationally in the same cycle.
- Then: push `w` into the tag FIFO, set `rr_q` to (w+1) mod NUM_CORES, clear `lock_q`.

**Response path**
- On `apu_rvalid_i`, when the FIFO is non-empty:
  - `core_apu_rvalid_o` = one-hot of the FIFO head; the head is popped.
  - `core_apu_result_o` and `core_apu_flags_o` = `apu_result_i` and `apu_flags_i`, passed through combinationally.
- The shared APU returns results in issue order.

**Boundaries**
- FIFO full: `apu_req_o`=0 and all grants are 0. A locked winner stays locked.
- Push and pop in the same cycle: occupancy is unchanged. This is legal at any occupancy below full. At full no push can occur, so a pop in the same cycle frees one entry for the next cycle.
- `apu_rvalid_i` with an empty FIFO: no `core_apu_rvalid_o` is asserted and `err_o` is set. `err_o` clears only on reset.
- Pointers wrap modulo MAX_OUTSTANDING, using an extra wrap bit to distinguish full from empty.
- Reset mid-operation: all state is cleared immediately and any in-flight tags are discarded. The shared APU must be reset together with this block.

## Timing
- **Reset values:** `rr_q`=0, `lock_q`=0, FIFO empty, `outstanding_o`=0, `err_o`=0. All grant/rvalid outputs are 0. `apu_req_o` is 0 unless a request is present.
- **Latency:** zero cycles from request to APU and from APU result to core; both paths are combinational.
- **Pointer update:** takes effect the cycle after a handshake.
- **Occupancy:** `outstanding_o` updates the cycle after a push or pop.
- **No combinational paths** from `apu_gnt_i` to `apu_req_o`, or from `apu_rvalid_i` to `apu_req_o`.
- **Throughput:** one issue per cycle and one result per cycle, sustained.

## Test plan
- **Fairness:** all 4 cores request continuously, `apu_gnt_i`=1, results returned 2 cycles later → grants go to cores 0,1,2,3,0… Each `core_apu_rvalid_o` matches its issuer in order.
- **Lock:** core 2 requests and `apu_gnt_i` is held 0 for 3 cycles while core 1 raises `req` → `apu_op_o` stays at core 2's op. Core 2 is granted on the first cycle with `gnt`=1. Core 1 is granted next.
- **Full FIFO:** 4 ops issued with no results → `outstanding_o`=4 and `apu_req_o`=0. One `apu_rvalid_i` arrives → `outstanding_o`=3 the next cycle and `apu_req_o`=1.
- **Simultaneous push and pop:** push and pop in the same cycle at occupancy 2 → occupancy stays 2. The rvalid goes to the oldest tag.
- **Spurious result:** `apu_rvalid_i`=1 with the FIFO empty → all `core_apu_rvalid_o`=0 and `err_o`=1 from the next cycle until reset.
- **Reset mid-operation:** `rst_i` asserted with 3 ops outstanding → `outstanding_o`=0 and `rr_q`=0. After release, the first grant goes to the lowest requesting core.
